// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_ctrl
//  Brief    : Multiply/divide sequencing controller for the execute stage.
//             Computes mult/multu/div/divu results up front, holds them in a
//             pending register pair while a busy counter models the HI/LO
//             unit latency, then commits them to the architectural HI/LO.
//             mthi/mtlo write HI/LO directly with single-edge latency.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] C_MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_N  = 4'(DIV_CYCLES);

  localparam logic [2:0] C_OP_MULT  = 3'd0;
  localparam logic [2:0] C_OP_MULTU = 3'd1;
  localparam logic [2:0] C_OP_DIV   = 3'd2;
  localparam logic [2:0] C_OP_DIVU  = 3'd3;
  localparam logic [2:0] C_OP_MTHI  = 3'd4;
  localparam logic [2:0] C_OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Datapath wires
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // One 64x64 multiplier serves both mult and multu: the low 64 bits of the
  // product of sign- or zero-extended operands is the correct result in
  // either case.
  always_comb begin
    w_mul_a = {{32{(op == C_OP_MULT) & a[31]}}, a};
    w_mul_b = {{32{(op == C_OP_MULT) & b[31]}}, b};
    w_prod  = w_mul_a * w_mul_b;
  end

  // Sign-magnitude divide: one unsigned divider, with signs fixed up after.
  // Quotient truncates toward zero, remainder takes the dividend's sign.
  // 0x80000000 / -1 falls out naturally as magnitude 0x80000000, negated.
  always_comb begin
    w_a_neg = (op == C_OP_DIV) & a[31];
    w_b_neg = (op == C_OP_DIV) & b[31];
    w_a_mag = w_a_neg ? (32'd0 - a) : a;
    w_b_mag = w_b_neg ? (32'd0 - b) : b;
    if (w_b_mag == 32'd0) begin
      // Result unused for divide-by-zero; keep the divider input defined.
      w_q_mag = 32'd0;
      w_r_mag = 32'd0;
    end else begin
      w_q_mag = w_a_mag / w_b_mag;
      w_r_mag = w_a_mag % w_b_mag;
    end
    w_quot = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    w_rem  = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
  end

  // Next-state, counter, pending-result and HI/LO update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            C_OP_MULT, C_OP_MULTU: begin
              p_hi_d  = w_prod[63:32];
              p_lo_d  = w_prod[31:0];
              cnt_d   = C_MULT_N;
              state_d = BUSY;
            end
            C_OP_DIV, C_OP_DIVU: begin
              if (b == 32'd0) begin
                // HI/LO cannot change while busy, so committing their
                // current values leaves them untouched.
                p_hi_d = hi_q;
                p_lo_d = lo_q;
              end else begin
                p_hi_d = w_rem;
                p_lo_d = w_quot;
              end
              cnt_d   = C_DIV_N;
              state_d = BUSY;
            end
            C_OP_MTHI: hi_d = a;
            C_OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // Any start while busy is ignored; the hazard unit stalls it.
        if (cnt_q <= 4'd1) begin
          hi_d    = p_hi_q;
          lo_d    = p_lo_q;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_ctrl
//  Brief    : Self-checking bench for mdu_ctrl. Two instances (default
//             latencies, and MULT=1/DIV=15) are compared every cycle against
//             a behavioural model; literal expectations pin known results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  busy_w;
  logic [31:0] hi_w [2];
  logic [31:0] lo_w [2];

  int checks = 0;
  int errors = 0;

  // Behavioural model: remaining busy cycles and pending/architected values
  int          n_mult [2] = '{5, 1};
  int          n_div  [2] = '{10, 15};
  int          m_rem  [2];
  logic [31:0] m_hi   [2];
  logic [31:0] m_lo   [2];
  logic [31:0] m_ph   [2];
  logic [31:0] m_pl   [2];

  mdu_ctrl dut0 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy_w[0]), .hi(hi_w[0]), .lo(lo_w[0])
  );

  mdu_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(15)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy_w[1]), .hi(hi_w[1]), .lo(lo_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_hi[i] = 0; m_lo[i] = 0; m_ph[i] = 0; m_pl[i] = 0;
    end
  endtask

  // Applies one clock edge of architectural behaviour to the model
  task automatic model_step();
    logic [63:0] p64;
    longint      sq, sr;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_rem[i] > 0) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_hi[i] = m_ph[i];
          m_lo[i] = m_pl[i];
        end
      end else if (start) begin
        case (op)
          3'd0: begin
            p64 = 64'(longint'($signed(a)) * longint'($signed(b)));
            m_ph[i] = p64[63:32]; m_pl[i] = p64[31:0]; m_rem[i] = n_mult[i];
          end
          3'd1: begin
            p64 = {32'd0, a} * {32'd0, b};
            m_ph[i] = p64[63:32]; m_pl[i] = p64[31:0]; m_rem[i] = n_mult[i];
          end
          3'd2: begin
            if (b == 0) begin
              m_ph[i] = m_hi[i]; m_pl[i] = m_lo[i];
            end else begin
              sq = longint'($signed(a)) / longint'($signed(b));
              sr = longint'($signed(a)) % longint'($signed(b));
              m_pl[i] = sq[31:0]; m_ph[i] = sr[31:0];
            end
            m_rem[i] = n_div[i];
          end
          3'd3: begin
            if (b == 0) begin
              m_ph[i] = m_hi[i]; m_pl[i] = m_lo[i];
            end else begin
              m_pl[i] = a / b; m_ph[i] = a % b;
            end
            m_rem[i] = n_div[i];
          end
          3'd4: m_hi[i] = a;
          3'd5: m_lo[i] = a;
          default: ;
        endcase
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy dut%0d", i), {31'd0, busy_w[i]}, {31'd0, (m_rem[i] > 0)});
      chk($sformatf("hi dut%0d", i), hi_w[i], m_hi[i]);
      chk($sformatf("lo dut%0d", i), lo_w[i], m_lo[i]);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1; op = o; a = va; b = vb;
    tick();
    start = 1'b0; op = 3'd7;
  endtask

  // Counts dut0 busy cycles, then lets dut1 drain too
  task automatic wait_idle(input int exp_len);
    int n = 0;
    int guard = 0;
    while (busy_w[0] && guard < 40) begin n++; guard++; tick(); end
    if (exp_len >= 0) chk("busy_len dut0", 32'(n), 32'(exp_len));
    guard = 0;
    while ((busy_w[0] || busy_w[1]) && guard < 40) begin guard++; tick(); end
    if (guard >= 40) begin
      errors++;
      $display("FAIL idle_timeout: got busy %b expected 00", busy_w);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd7; a = 0; b = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy_w[0]}, 32'd0);
    chk("reset hi", hi_w[0], 32'd0);
    chk("reset lo", lo_w[0], 32'd0);
    reset = 1'b0;
    tick();

    do_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(5);
    chk("mult hi", hi_w[0], 32'hFFFF_FFFF);
    chk("mult lo", lo_w[0], 32'hFFFF_FFFA);

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(5);
    chk("multu hi", hi_w[0], 32'hFFFF_FFFE);
    chk("multu lo", lo_w[0], 32'h0000_0001);

    do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(10);
    chk("div hi", hi_w[0], 32'hFFFF_FFFF);
    chk("div lo", lo_w[0], 32'hFFFF_FFFD);

    do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(10);
    chk("divu hi", hi_w[0], 32'h0000_0001);
    chk("divu lo", lo_w[0], 32'h7FFF_FFFC);

    do_op(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi hi", hi_w[0], 32'h1234_5678);
    chk("mthi busy", {31'd0, busy_w[0]}, 32'd0);
    do_op(3'd3, 32'd99, 32'd0);
    wait_idle(10);
    chk("div0 hi", hi_w[0], 32'h1234_5678);
    chk("div0 lo", lo_w[0], 32'h7FFF_FFFC);

    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(10);
    chk("div ovf hi", hi_w[0], 32'h0000_0000);
    chk("div ovf lo", lo_w[0], 32'h8000_0000);

    do_op(3'd0, 32'd3, 32'd4);
    tick();
    start = 1'b1; op = 3'd5; a = 32'h0000_AAAA;
    tick();
    start = 1'b0; op = 3'd7;
    wait_idle(-1);
    chk("ignored mtlo lo", lo_w[0], 32'd12);
    chk("ignored mtlo hi", hi_w[0], 32'd0);

    // Single-cycle latency instance
    do_op(3'd0, 32'd7, 32'd6);
    chk("n1 busy", {31'd0, busy_w[1]}, 32'd1);
    tick();
    chk("n1 busy fall", {31'd0, busy_w[1]}, 32'd0);
    chk("n1 lo", lo_w[1], 32'd42);
    wait_idle(-1);

    // Randomized traffic, including starts while busy
    for (int k = 0; k < 600; k++) begin
      start = (($urandom % 3) == 0);
      op    = 3'($urandom % 8);
      a     = pick();
      b     = pick();
      tick();
    end
    start = 1'b0; op = 3'd7;
    wait_idle(-1);

    // Reset in the fourth busy cycle of a divide
    do_op(3'd2, 32'd100, 32'd7);
    repeat (3) tick();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async rst busy", {31'd0, busy_w[0]}, 32'd0);
    chk("async rst hi", hi_w[0], 32'd0);
    chk("async rst lo", lo_w[0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) tick();
    chk("post rst hi", hi_w[0], 32'd0);
    chk("post rst lo", lo_w[0], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencing controller for the pipelined MIPS core's execute stage. It accepts mult/multu/div/divu/mthi/mtlo commands from E, models the multi-cycle latency of the HI/LO unit with a busy counter, and commits results to the architectural HI and LO registers. The hazard unit reads `busy` and `start` to stall mfhi/mflo and further MD instructions in D.

## Interface

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (legal 1..15)
- DIV_CYCLES, 10, busy duration for div/divu (legal 1..15)

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  E-stage MD instruction valid this cycle
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
- a  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- b  input  32  rt operand (divisor / multiplier)
- busy  output  1  operation in flight; registered
- hi  output  32  architectural HI register; registered
- lo  output  32  architectural LO register; registered

## Operation

- States: IDLE, BUSY. 4-bit down-counter `cnt`, pending result registers `p_hi`, `p_lo`.
- IDLE, start=1, op 0..3: compute result from a, b combinationally, latch into p_hi/p_lo, load cnt with MULT_CYCLES or DIV_CYCLES, go BUSY.
- mult: {p_hi,p_lo} = signed(a) * signed(b), 64-bit. multu: unsigned 64-bit product.
- div: p_lo = signed quotient truncated toward zero, p_hi = remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (b=0, div or divu): still busy for DIV_CYCLES; HI/LO left unchanged at completion.
- IDLE, start=1, op 4: hi <= a at next edge; op 5: lo <= a. No BUSY entry. op 6/7: nothing.
- BUSY: cnt decrements each edge; at edge where cnt==1, hi<=p_hi, lo<=p_lo, go IDLE.
- BUSY, start=1 (any op): ignored entirely (hazard unit must stall; ignoring is the defined safe behaviour). Operands not re-sampled.
- busy = (state==BUSY).

## Timing

- Reset values: busy=0, hi=0, lo=0, state IDLE, cnt=0, p_hi=p_lo=0. Reset mid-operation discards pending result; HI/LO read 0 after release.
- start sampled at edge E0 (op 0..3): busy=1 after E0 through edge E0+N, where N = MULT_CYCLES or DIV_CYCLES; busy high for exactly N cycles.
- hi/lo update at edge E0+N, same edge busy falls. mfhi in the cycle after reads new value.
- New start accepted in the cycle busy first reads 0 (back-to-back: second op starts at E0+N, busy never drops for observable cycle only if start sampled that edge — busy falls then rises next; no, see: start sampled when state is IDLE, i.e. at E0+N+1 earliest -> busy low one cycle minimum between ops).
- mthi/mtlo: single-edge latency, busy stays 0.
- N=1: busy high one cycle, HI/LO update at E0+1.

## Test plan

- Reset, then mult a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu same operands -> lo=0x7FFFFFFC, hi=1.
- mthi 0x12345678, then divu b=0 -> busy 10 cycles, hi stays 0x12345678, lo unchanged.
- Start mult, pulse start with mtlo 0xAAAA during busy cycle 2 -> ignored; final lo = mult result, not 0xAAAA.
- Start div, assert reset in busy cycle 4 -> busy, hi, lo go 0 immediately (asynchronous); after release no late commit occurs.
